// File: rtl/hamming74_pkg.sv
// Shared constants and FSM encoding for the serial Hamming(7,4) receive decoder.
// Optional corrected-error counter is enabled by the HAM_ERR_CNT_EN macro.
package hamming74_pkg;

  localparam int CW_LEN = 7;
  localparam int DATA_W = 4;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EMIT    = 2'd2
  } state_e;

  // Bit i of a mask is codeword position i+1; a position is covered by syndrome
  // bit k when bit k of its position number is set.
  localparam logic [CW_LEN-1:0] SYN_MASK_S1 = 7'b1010101;
  localparam logic [CW_LEN-1:0] SYN_MASK_S2 = 7'b1100110;
  localparam logic [CW_LEN-1:0] SYN_MASK_S3 = 7'b1111000;

endpackage

// File: rtl/hamming74_syndrome.sv
// Combinational Hamming(7,4) syndrome and single-bit correction.
// cw_i[0] holds codeword position 1, cw_i[6] holds position 7.
module hamming74_syndrome
  import hamming74_pkg::*;
(
  input  logic [CW_LEN-1:0] cw_i,
  output logic [2:0]        syn_o,
  output logic [DATA_W-1:0] data_o
);

  logic [2:0]        syn;
  logic [CW_LEN-1:0] fixed;

  always_comb begin
    syn   = {^(cw_i & SYN_MASK_S3), ^(cw_i & SYN_MASK_S2), ^(cw_i & SYN_MASK_S1)};
    fixed = cw_i;
    if (syn != 3'd0) begin
      fixed[syn - 3'd1] = ~cw_i[syn - 3'd1];
    end
    syn_o  = syn;
    data_o = {fixed[2], fixed[4], fixed[5], fixed[6]};
  end

endmodule

// File: rtl/hamming74_rx_decoder.sv
// Serial Hamming(7,4) receiver: collects 7 bits, corrects one error, emits data.
// Define HAM_ERR_CNT_EN to add the saturating corr_count output (width CNT_W).
module hamming74_rx_decoder
  import hamming74_pkg::*;
`ifdef HAM_ERR_CNT_EN
#(
  parameter int CNT_W = 8
)
`endif
(
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [3:0]       data_out,
  output logic             data_valid,
  output logic             err_corr,
  output logic [2:0]       err_pos
`ifdef HAM_ERR_CNT_EN
  ,
  output logic [CNT_W-1:0] corr_count
`endif
);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [CW_LEN-1:0]   sh_q, sh_d;
  logic [2:0]          syn_q, syn_d;
  logic [DATA_W-1:0]   fix_q, fix_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [2:0]          pos_q, pos_d;
  logic                corr_q, corr_d;
  logic                dv_q, dv_d;

  logic [2:0]          syn_w;
  logic [DATA_W-1:0]   fix_w;

  hamming74_syndrome u_syndrome (
    .cw_i   (sh_q),
    .syn_o  (syn_w),
    .data_o (fix_w)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    syn_d     = syn_q;
    fix_d     = fix_q;
    data_d    = data_q;
    pos_d     = pos_q;
    corr_d    = corr_q;
    dv_d      = 1'b0;
    bit_ready = 1'b0;
    case (state_q)
      ST_COLLECT: begin
        bit_ready = 1'b1;
        if (bit_valid) begin
          // First received bit ends up in sh_q[0] after seven shifts.
          sh_d = {bit_in, sh_q[CW_LEN-1:1]};
          if (cnt_q == 3'(CW_LEN - 1)) begin
            cnt_d   = 3'd0;
            state_d = ST_DECODE;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      ST_DECODE: begin
        syn_d   = syn_w;
        fix_d   = fix_w;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        data_d  = fix_q;
        pos_d   = syn_q;
        corr_d  = (syn_q != 3'd0);
        dv_d    = 1'b1;
        cnt_d   = 3'd0;
        state_d = ST_COLLECT;
      end
      default: begin
        state_d = ST_COLLECT;
        cnt_d   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_COLLECT;
      cnt_q   <= '0;
      sh_q    <= '0;
      syn_q   <= '0;
      fix_q   <= '0;
      data_q  <= '0;
      pos_q   <= '0;
      corr_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      syn_q   <= syn_d;
      fix_q   <= fix_d;
      data_q  <= data_d;
      pos_q   <= pos_d;
      corr_q  <= corr_d;
      dv_q    <= dv_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = dv_q;
  assign err_corr   = corr_q;
  assign err_pos    = pos_q;

`ifdef HAM_ERR_CNT_EN
  logic [CNT_W-1:0] ecnt_q, ecnt_d;

  always_comb begin
    ecnt_d = ecnt_q;
    if (state_q == ST_EMIT && syn_q != 3'd0 && ecnt_q != {CNT_W{1'b1}}) begin
      ecnt_d = ecnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ecnt_q <= '0;
    end else begin
      ecnt_q <= ecnt_d;
    end
  end

  assign corr_count = ecnt_q;
`endif

endmodule
